ebus_arbiter: RTL and testbench
===============================

Name: ebus_arbiter

Overview:
- Parametrised EBUS data arbiter. It merges NDRV module driver channels into the single 36-bit EBUS data path using fixed priority, and OR-merges bit-slice driver groups (CRM/EDP style).
- It adds behaviour the flat priority mux lacks:
  - an optional registered output stage;
  - contention detection with a sticky first-offender capture and a saturating counter;
  - a demand/xfer handshake watchdog.
- It sits at the backplane level between the per-module driver records and the ebus interface.

Parameters:
- NDRV, 32, number of driver channels; index 0 has the highest priority.
- WIDTH, 36, EBUS data width.
- SLICE_MASK, 0, NDRV-bit mask of channels that are partial-width slice drivers.
- REGOUT, 1, 1 = registered data/valid (1-cycle latency); 0 = combinational.
- TIMEOUT, 15, cycles allowed from demand rise to xfer before a timeout is flagged; must be ≥ 1.
- CNTW, 8, width of the contention counter.

Ports:
- clk  in  1  system clock.
- crobar  in  1  asynchronous active-high reset.
- drv_driving  in  NDRV  per-channel driving request.
- drv_data  in  NDRV*WIDTH  per-channel data; channel i occupies [i*WIDTH +: WIDTH].
- demand  in  1  EBUS demand.
- xfer  in  1  EBUS xfer.
- clr  in  1  synchronous clear of the diagnostic state.
- ebus_data  out  WIDTH  arbitrated EBUS data.
- ebus_valid  out  1  some channel (or slice group) won.
- grant  out  NDRV  one-hot winner; all slice members set when the group wins.
- conflict  out  1  sticky contention flag.
- conflict_idx  out  $clog2(NDRV)  second-priority offender of the first contention.
- conflict_cnt  out  CNTW  saturating count of contention cycles.
- timeout  out  1  sticky handshake timeout flag.

Behaviour:
- **Reset.** While crobar=1, all outputs and registers are 0 asynchronously: ebus_data, ebus_valid, grant, conflict, conflict_idx, conflict_cnt, timeout, and the watchdog counter.
- **Slice group.** The channels in SLICE_MASK form one arbitration entry.
  - Its priority position is the lowest index set in SLICE_MASK.
  - It is active if any member is driving.
  - Its data is the bitwise OR of drv_data over *all* members, including non-driving ones; slice members drive 0 outside their slice.
  - If SLICE_MASK=0 there is no group.
- **Arbitration.** The winner is the lowest-priority-position active entry.
  - ebus_data = the winner's data; grant = the winner one-hot, or the slice-member mask; ebus_valid = 1.
  - With no active entry: ebus_data = 0, grant = 0, ebus_valid = 0.
- **Latency.**
  - REGOUT=1: ebus_data, grant and ebus_valid are registered on the rising edge of clk, so the driver-to-bus latency is 1 cycle.
  - REGOUT=0: these outputs are combinational with 0 latency.
  - Diagnostic state is always registered.
- **Contention.** Contention is a cycle where ≥2 arbitration entries are active; multiple slice members count as one entry.
  - Each contention cycle increments conflict_cnt, saturating at 2^CNTW-1 with no wrap.
  - On the first contention after reset/clr, conflict←1 and conflict_idx← the channel index of the second-highest-priority active entry (the lowest member index for the slice group).
  - Later contentions leave conflict_idx unchanged.
- **Watchdog.** States are IDLE, WAIT, DONE.
  - IDLE: on demand=1 & xfer=0, load the counter=TIMEOUT and go to WAIT. On demand=1 & xfer=1, go to DONE.
  - WAIT: if xfer=1, go to DONE. Else if the counter=1, set timeout←1 and go to DONE. Else decrement the counter. If demand drops, return to IDLE with no flag.
  - DONE: stay while demand=1; go to IDLE when demand=0.
  - A timeout is flagged exactly TIMEOUT cycles after the demand-rise edge if xfer never arrives.
- **clr.** Synchronous. It zeroes conflict, conflict_idx, conflict_cnt and timeout, and returns the watchdog to IDLE.
  - If clr and a contention or timeout event fall in the same cycle, clr wins; the event is dropped.
  - clr does not affect data, grant or valid.
- **Reset mid-operation.** Asserting crobar mid-handshake or mid-transfer clears all state immediately. After release the block starts in IDLE, with ebus_valid=0 until the next edge at which a driver is active.

Test Plan:
- **Reset and idle.** Hold crobar=1 with ch3 driving 0o123 → all outputs 0. Release, REGOUT=1 → after 1 clk, ebus_data=0o123, grant=1<<3, ebus_valid=1.
- **Priority.** ch5=0o777 and ch9=0o111 driving simultaneously → ebus_data=0o777, grant=1<<5. Contention gives conflict=1, conflict_idx=9, conflict_cnt=1. Hold 3 more cycles → cnt=4 and idx stays 9.
- **Slice merge.** SLICE_MASK=ch10..ch15, each driving its own 6-bit field, with 0o707070707070 overall → ebus_data=0o707070707070, grant=0xFC00, conflict=0. Adding ch2 → ch2 wins, conflict_idx=10.
- **Saturation.** CNTW=4 with 20 contention cycles → conflict_cnt=15. Pulse clr → cnt=0 and conflict=0 next cycle.
- **Watchdog.** TIMEOUT=15, raise demand without xfer → timeout=1 exactly 15 cycles later. Repeat with xfer at cycle 14 → timeout stays 0. Demand drop at cycle 5 → IDLE, no flag.
- **Reset mid-WAIT / clr collision.** crobar pulse at cycle 7 of WAIT → timeout stays 0 and a fresh demand restarts the full 15-cycle window. clr coincident with a contention cycle → cnt=0 and conflict=0.

Source files
------------

// File: rtl/ebus_arbiter.sv
// EBUS data arbiter: fixed-priority merge of driver channels with an OR-merged slice group,
// optional output register, contention diagnostics and a demand/xfer watchdog.
module ebus_arbiter #(
    parameter int               NDRV       = 32,
    parameter int               WIDTH      = 36,
    parameter logic [NDRV-1:0]  SLICE_MASK = '0,
    parameter bit               REGOUT     = 1'b1,
    parameter int               TIMEOUT    = 15,
    parameter int               CNTW       = 8,
    localparam int              IW         = (NDRV > 1) ? $clog2(NDRV) : 1
) (
    input  logic                  clk,
    input  logic                  crobar,
    input  logic [NDRV-1:0]       drv_driving,
    input  logic [NDRV*WIDTH-1:0] drv_data,
    input  logic                  demand,
    input  logic                  xfer,
    input  logic                  clr,
    output logic [WIDTH-1:0]      ebus_data,
    output logic                  ebus_valid,
    output logic [NDRV-1:0]       grant,
    output logic                  conflict,
    output logic [IW-1:0]         conflict_idx,
    output logic [CNTW-1:0]       conflict_cnt,
    output logic                  timeout
);

    localparam int TW = $clog2(TIMEOUT + 1);

    function automatic int lowest_set(input logic [NDRV-1:0] m);
        int r = 0;
        for (int i = NDRV - 1; i >= 0; i--) begin
            if (m[i]) r = i;
        end
        return r;
    endfunction

    localparam bit HAS_SLICE  = |SLICE_MASK;
    localparam int SLICE_LEAD = lowest_set(SLICE_MASK);

    typedef enum logic [1:0] {WD_IDLE, WD_WAIT, WD_DONE} wd_state_t;

    logic              slice_act;
    logic [WIDTH-1:0]  slice_data;
    logic [WIDTH-1:0]  arb_data;
    logic [NDRV-1:0]   arb_grant;
    logic              arb_valid;
    logic              contention;
    logic [IW-1:0]     second_idx;

    wd_state_t         wd_state, wd_state_n;
    logic [TW-1:0]     wd_cnt, wd_cnt_n;
    logic              timeout_n;

    // The slice group takes the priority slot of its lowest member; other members are skipped.
    always_comb begin : arb_comb
        logic entry_act;
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        entry_act  = 1'b0;
        slice_act  = |(drv_driving & SLICE_MASK);
        slice_data = '0;
        arb_data   = '0;
        arb_grant  = '0;
        arb_valid  = 1'b0;
        contention = 1'b0;
        second_idx = '0;
        for (int i = 0; i < NDRV; i++) begin
            if (SLICE_MASK[i]) slice_data |= drv_data[i*WIDTH +: WIDTH];
        end
        for (int i = 0; i < NDRV; i++) begin
            if (HAS_SLICE && i == SLICE_LEAD) entry_act = slice_act;
            else                              entry_act = drv_driving[i] && !SLICE_MASK[i];
            if (entry_act) begin
                if (!arb_valid) begin
                    arb_valid = 1'b1;
                    if (HAS_SLICE && i == SLICE_LEAD) begin
                        arb_data  = slice_data;
                        arb_grant = SLICE_MASK;
                    end else begin
                        arb_data     = drv_data[i*WIDTH +: WIDTH];
                        arb_grant[i] = 1'b1;
                    end
                end else if (!contention) begin
                    contention = 1'b1;
                    second_idx = IW'(i);
                end
            end
        end
    end

    generate
        if (REGOUT) begin : g_regout
            always_ff @(posedge clk or posedge crobar) begin
                // NOTE: sequential state uses non-blocking assignments so all flops update together.
                if (crobar) begin
                    ebus_data  <= '0;
                    grant      <= '0;
                    ebus_valid <= 1'b0;
                end else begin
                    ebus_data  <= arb_data;
                    grant      <= arb_grant;
                    ebus_valid <= arb_valid;
                end
            end
        end else begin : g_combout
            assign ebus_data  = arb_data;
            assign grant      = arb_grant;
            assign ebus_valid = arb_valid;
        end
    endgenerate

    // clr outranks a same-cycle contention event; only the first contention captures the index.
    always_ff @(posedge clk or posedge crobar) begin
        if (crobar) begin
            conflict     <= 1'b0;
            conflict_idx <= '0;
            conflict_cnt <= '0;
        end else if (clr) begin
            conflict     <= 1'b0;
            conflict_idx <= '0;
            conflict_cnt <= '0;
        end else if (contention) begin
            if (conflict_cnt != '1) conflict_cnt <= conflict_cnt + 1'b1;
            if (!conflict) begin
                conflict     <= 1'b1;
                conflict_idx <= second_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge crobar) begin
        if (crobar) begin
            wd_state <= WD_IDLE;
            wd_cnt   <= '0;
            timeout  <= 1'b0;
        end else begin
            wd_state <= wd_state_n;
            wd_cnt   <= wd_cnt_n;
            timeout  <= timeout_n;
        end
    end

    always_comb begin
        wd_state_n = wd_state;
        wd_cnt_n   = wd_cnt;
        timeout_n  = timeout;
        unique case (wd_state)
            WD_IDLE: begin
                if (demand && !xfer) begin
                    wd_cnt_n   = TW'(TIMEOUT);
                    wd_state_n = WD_WAIT;
                end else if (demand && xfer) begin
                    wd_state_n = WD_DONE;
                end
            end
            WD_WAIT: begin
                if (!demand) begin
                    wd_state_n = WD_IDLE;
                end else if (xfer) begin
                    wd_state_n = WD_DONE;
                end else if (wd_cnt == TW'(1)) begin
                    timeout_n  = 1'b1;
                    wd_state_n = WD_DONE;
                end else begin
                    wd_cnt_n = wd_cnt - 1'b1;
                end
            end
            WD_DONE: begin
                if (!demand) wd_state_n = WD_IDLE;
            end
            default: wd_state_n = WD_IDLE;
        endcase
        if (clr) begin
            wd_state_n = WD_IDLE;
            wd_cnt_n   = '0;
            timeout_n  = 1'b0;
        end
    end

endmodule

// File: tb/tb_ebus_arbiter.sv
// Self-checking bench for ebus_arbiter: scoreboard of bus/diagnostic expectations plus
// directed watchdog and reset checks.
module tb_ebus_arbiter;

    localparam int NDRV       = 32;
    localparam int W          = 36;
    localparam int CNTW       = 4;
    localparam int TO         = 15;
    localparam int SLICE_LEAD = 10;

    typedef struct packed {
        logic [W-1:0]    data;
        logic [NDRV-1:0] grant;
        logic            valid;
        logic            conf;
        logic [4:0]      idx;
        logic [CNTW-1:0] cnt;
    } exp_t;

    logic                clk = 1'b0;
    logic                crobar;
    logic [NDRV-1:0]     drv_driving;
    logic [NDRV*W-1:0]   drv_data;
    logic                demand, xfer, clr;
    logic [W-1:0]        ebus_data;
    logic                ebus_valid;
    logic [NDRV-1:0]     grant;
    logic                conflict;
    logic [4:0]          conflict_idx;
    logic [CNTW-1:0]     conflict_cnt;
    logic                timeout;

    logic [NDRV-1:0]     mask_v = 32'h0000_FC00;
    exp_t                sb_q[$];
    logic                m_conf;
    logic [4:0]          m_idx;
    logic [CNTW-1:0]     m_cnt;
    int                  n_chk = 0;
    int                  n_err = 0;

    ebus_arbiter #(
        .NDRV(NDRV), .WIDTH(W), .SLICE_MASK(32'h0000_FC00),
        .REGOUT(1'b1), .TIMEOUT(TO), .CNTW(CNTW)
    ) dut (
        .clk(clk), .crobar(crobar), .drv_driving(drv_driving), .drv_data(drv_data),
        .demand(demand), .xfer(xfer), .clr(clr),
        .ebus_data(ebus_data), .ebus_valid(ebus_valid), .grant(grant),
        .conflict(conflict), .conflict_idx(conflict_idx), .conflict_cnt(conflict_cnt),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic clear_drv();
        drv_driving = '0;
        drv_data    = '0;
    endtask

    task automatic set_ch(input int c, input logic [W-1:0] v);
        drv_driving[c]       = 1'b1;
        drv_data[c*W +: W]   = v;
    endtask

    // Model: the lowest driving channel wins; if it is a slice member the whole group wins.
    task automatic predict();
        exp_t         e;
        int           first, second;
        logic [W-1:0] gd;
        e = '0; first = -1; second = -1; gd = '0;
        for (int c = 0; c < NDRV; c++)
            if (mask_v[c]) gd |= drv_data[c*W +: W];
        for (int c = 0; c < NDRV; c++) begin
            if (drv_driving[c]) begin
                if (first < 0) first = c;
                else if (second < 0 && !(mask_v[first] && mask_v[c]))
                    second = mask_v[c] ? SLICE_LEAD : c;
            end
        end
        if (first >= 0) begin
            e.valid = 1'b1;
            if (mask_v[first]) begin
                e.data  = gd;
                e.grant = mask_v;
            end else begin
                e.data  = drv_data[first*W +: W];
                e.grant = 32'(1) << first;
            end
        end
        if (clr) begin
            m_conf = 1'b0; m_idx = '0; m_cnt = '0;
        end else if (second >= 0) begin
            if (m_cnt != '1) m_cnt++;
            if (!m_conf) begin
                m_conf = 1'b1;
                m_idx  = 5'(second);
            end
        end
        e.conf = m_conf; e.idx = m_idx; e.cnt = m_cnt;
        sb_q.push_back(e);
    endtask

    task automatic cycle();
        exp_t e;
        predict();
        @(posedge clk); #1;
        check("sb_depth", 64'(sb_q.size()), 64'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("data",  64'(ebus_data),    64'(e.data));
            check("grant", 64'(grant),        64'(e.grant));
            check("valid", 64'(ebus_valid),   64'(e.valid));
            check("conf",  64'(conflict),     64'(e.conf));
            check("idx",   64'(conflict_idx), 64'(e.idx));
            check("cnt",   64'(conflict_cnt), 64'(e.cnt));
        end
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_conf = 1'b0; m_idx = '0; m_cnt = '0;
    endtask

    task automatic clr_pulse();
        clr = 1'b1; cycle(); clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        crobar = 1'b1; demand = 1'b0; xfer = 1'b0; clr = 1'b0;
        clear_drv();
        model_reset();
        set_ch(3, 36'o123);
        repeat (3) @(posedge clk);
        #1;
        check("rst_data",  64'(ebus_data),    0);
        check("rst_valid", 64'(ebus_valid),   0);
        check("rst_grant", 64'(grant),        0);
        check("rst_conf",  64'(conflict),     0);
        check("rst_idx",   64'(conflict_idx), 0);
        check("rst_cnt",   64'(conflict_cnt), 0);
        check("rst_to",    64'(timeout),      0);

        crobar = 1'b0;
        cycle();
        check("ch3_data",  64'(ebus_data), 64'(36'o123));
        check("ch3_grant", 64'(grant),     64'(32'h8));

        clear_drv();
        set_ch(5, 36'o777);
        set_ch(9, 36'o111);
        cycle();
        check("pri_data",  64'(ebus_data),    64'(36'o777));
        check("pri_grant", 64'(grant),        64'(32'h20));
        check("pri_conf",  64'(conflict),     1);
        check("pri_idx",   64'(conflict_idx), 9);
        check("pri_cnt",   64'(conflict_cnt), 1);
        repeat (3) cycle();
        check("pri_cnt4",  64'(conflict_cnt), 4);
        check("pri_idx9",  64'(conflict_idx), 9);

        clear_drv();
        clr_pulse();
        for (int c = 10; c < 16; c++) set_ch(c, 36'(6'o70) << ((c - 10) * 6));
        cycle();
        check("slc_data",  64'(ebus_data), 64'(36'o707070707070));
        check("slc_grant", 64'(grant),     64'(32'hFC00));
        check("slc_conf",  64'(conflict),  0);
        set_ch(2, 36'o2222);
        cycle();
        check("slc_ch2_grant", 64'(grant),        64'(32'h4));
        check("slc_ch2_idx",   64'(conflict_idx), 10);

        clear_drv();
        clr_pulse();
        set_ch(5, 36'o777);
        set_ch(9, 36'o111);
        repeat (20) cycle();
        check("sat_cnt", 64'(conflict_cnt), 15);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        check("clr_coll_cnt",  64'(conflict_cnt), 0);
        check("clr_coll_conf", 64'(conflict),     0);
        cycle();

        for (int n = 0; n < 40; n++) begin
            drv_driving = $urandom & $urandom & $urandom;
            for (int c = 0; c < NDRV; c++) begin
                if (mask_v[c]) drv_data[c*W +: W] = 36'($urandom_range(0, 63)) << ((c - 10) * 6);
                else           drv_data[c*W +: W] = W'({$urandom, $urandom});
            end
            clr = ($urandom_range(0, 7) == 0);
            cycle();
        end
        clr = 1'b0;

        clear_drv();
        clr_pulse();
        demand = 1'b1;
        repeat (TO) cycle();
        check("wd_to_early", 64'(timeout), 0);
        cycle();
        check("wd_to_exact", 64'(timeout), 1);

        demand = 1'b0;
        clr_pulse();
        demand = 1'b1;
        repeat (14) cycle();
        xfer = 1'b1;
        cycle();
        xfer = 1'b0;
        repeat (5) cycle();
        check("wd_xfer_ok", 64'(timeout), 0);

        demand = 1'b0;
        cycle();
        demand = 1'b1;
        repeat (5) cycle();
        demand = 1'b0;
        repeat (20) cycle();
        check("wd_drop_ok", 64'(timeout), 0);

        demand = 1'b1;
        repeat (8) cycle();
        crobar = 1'b1;
        #2;
        check("wd_rst_to",    64'(timeout),    0);
        check("wd_rst_valid", 64'(ebus_valid), 0);
        demand = 1'b0;
        @(negedge clk);
        crobar = 1'b0;
        model_reset();
        demand = 1'b1;
        repeat (TO) cycle();
        check("wd_fresh_early", 64'(timeout), 0);
        cycle();
        check("wd_fresh_exact", 64'(timeout), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
